servo_sweep_ctrl: RTL and testbench

- Drives the horizontal and vertical servos through a stepped sweep.
- Presents each commanded pulse width, with its EN_H/EN_V qualifier, to the max-value register array.
- After each axis sweep, reads back the stored pulseWidth_max and parks that servo at the best position.
- Generates both servo PWM waveforms; sits between the top-level control and the comparator/register array.

---
 rtl/servo_sweep_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_servo_sweep_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/servo_sweep_ctrl.sv
// Two-axis servo sweep controller: steps each axis through its pulse-width range,
// strobes SAMPLE per point, parks at the stored best width. Optional: AUTO_RESWEEP_EN.
module servo_sweep_ctrl #(
  parameter logic [31:0] PERIOD_CYC    = 32'd2000000,
  parameter logic [31:0] PW_MIN        = 32'd50000,
  parameter logic [31:0] PW_MAX        = 32'd250000,
  parameter logic [31:0] PW_STEP       = 32'd10000,
  parameter logic [31:0] SETTLE_FRAMES = 32'd2
`ifdef AUTO_RESWEEP_EN
  ,
  parameter logic [31:0] RESWEEP_FRAMES = 32'd500
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        GT,
  input  logic [31:0] pulseWidth_max,
  output logic [31:0] pulseWidth_H,
  output logic [31:0] pulseWidth_V,
  output logic        EN_H,
  output logic        EN_V,
  output logic        SAMPLE,
  output logic        PWM_H,
  output logic        PWM_V,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [31:0] PW_MID = (PW_MIN + PW_MAX) / 32'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWEEP_H,
    S_PARK_H,
    S_SWEEP_V,
    S_PARK_V,
    S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] settle_cnt_q, settle_cnt_d;
  logic        pend_q, pend_d;
  logic        park_cnt_q, park_cnt_d;
  logic [31:0] pw_h_q, pw_h_d;
  logic [31:0] pw_v_q, pw_v_d;
  logic [31:0] act_h_q, act_h_d;
  logic [31:0] act_v_q, act_v_d;
  logic        pwm_en_q, pwm_en_d;
  logic        pwm_h_q, pwm_h_d;
  logic        pwm_v_q, pwm_v_d;
  logic        en_h_q, en_h_d;
  logic        en_v_q, en_v_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        gt_seen_q, gt_seen_d;

  logic        frame_last;
  logic        sweeping;
  logic        point_done;
  logic        step_ok;
  logic        go;
  logic [31:0] cur_pw;

`ifdef AUTO_RESWEEP_EN
  logic [31:0] rs_cnt_q, rs_cnt_d;
  logic        auto_go;
`endif

  always_comb begin
    frame_last  = (frame_cnt_q == PERIOD_CYC - 32'd1);
    frame_cnt_d = frame_last ? 32'd0 : frame_cnt_q + 32'd1;

    // New widths take effect only at a frame boundary; PWM stays off until the first sweep.
    act_h_d = (pwm_en_q && frame_cnt_q == 32'd0) ? pw_h_q : act_h_q;
    act_v_d = (pwm_en_q && frame_cnt_q == 32'd0) ? pw_v_q : act_v_q;
    pwm_h_d = (frame_cnt_q < act_h_d);
    pwm_v_d = (frame_cnt_q < act_v_d);

    sweeping   = (state_q == S_SWEEP_H) || (state_q == S_SWEEP_V);
    point_done = sweeping && !pend_q && frame_last &&
                 (settle_cnt_q == SETTLE_FRAMES - 32'd1);
    cur_pw     = (state_q == S_SWEEP_H) ? pw_h_q : pw_v_q;
    step_ok    = ((cur_pw + PW_STEP) <= PW_MAX);

`ifdef AUTO_RESWEEP_EN
    auto_go  = (state_q == S_IDLE) && done_q && frame_last &&
               (rs_cnt_q == RESWEEP_FRAMES - 32'd1);
    rs_cnt_d = rs_cnt_q;
    if (state_q != S_IDLE || START) begin
      rs_cnt_d = 32'd0;
    end else if (done_q && frame_last) begin
      rs_cnt_d = auto_go ? 32'd0 : rs_cnt_q + 32'd1;
    end
    go = START || auto_go;
`else
    go = START;
`endif
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    pend_d       = pend_q;
    park_cnt_d   = park_cnt_q;
    pw_h_d       = pw_h_q;
    pw_v_d       = pw_v_q;
    pwm_en_d     = pwm_en_q;
    en_h_d       = en_h_q;
    en_v_d       = en_v_q;
    busy_d       = busy_q;
    done_d       = done_q;
    gt_seen_d    = gt_seen_q;

    // A point waits (pend) for its first boundary, then settles for whole frames.
    if (sweeping) begin
      if (pend_q) begin
        if (frame_cnt_q == 32'd0) begin
          pend_d       = 1'b0;
          settle_cnt_d = 32'd0;
        end
      end else if (frame_last && !point_done) begin
        settle_cnt_d = settle_cnt_q + 32'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d      = S_SWEEP_H;
          pw_h_d       = PW_MIN;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          en_h_d       = 1'b1;
          pend_d       = 1'b1;
          settle_cnt_d = 32'd0;
          pwm_en_d     = 1'b1;
        end
      end
      S_SWEEP_H: begin
        if (point_done) begin
          if (step_ok) begin
            pw_h_d       = pw_h_q + PW_STEP;
            pend_d       = 1'b1;
            settle_cnt_d = 32'd0;
          end else begin
            state_d    = S_PARK_H;
            en_h_d     = 1'b0;
            park_cnt_d = 1'b0;
          end
        end
      end
      S_PARK_H: begin
        if (!park_cnt_q) begin
          park_cnt_d = 1'b1;
        end else begin
          pw_h_d       = pulseWidth_max;
          state_d      = S_SWEEP_V;
          pw_v_d       = PW_MIN;
          en_v_d       = 1'b1;
          gt_seen_d    = 1'b0;
          pend_d       = 1'b1;
          settle_cnt_d = 32'd0;
        end
      end
      S_SWEEP_V: begin
        if (point_done) begin
          if (GT) begin
            gt_seen_d = 1'b1;
          end
          if (step_ok) begin
            pw_v_d       = pw_v_q + PW_STEP;
            pend_d       = 1'b1;
            settle_cnt_d = 32'd0;
          end else begin
            state_d    = S_PARK_V;
            en_v_d     = 1'b0;
            park_cnt_d = 1'b0;
          end
        end
      end
      S_PARK_V: begin
        if (!park_cnt_q) begin
          park_cnt_d = 1'b1;
        end else begin
          // With no vertical winner the array still holds the horizontal max.
          pw_v_d  = gt_seen_q ? pulseWidth_max : PW_MID;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      frame_cnt_q  <= 32'd0;
      settle_cnt_q <= 32'd0;
      pend_q       <= 1'b0;
      park_cnt_q   <= 1'b0;
      pw_h_q       <= PW_MID;
      pw_v_q       <= PW_MID;
      act_h_q      <= 32'd0;
      act_v_q      <= 32'd0;
      pwm_en_q     <= 1'b0;
      pwm_h_q      <= 1'b0;
      pwm_v_q      <= 1'b0;
      en_h_q       <= 1'b0;
      en_v_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      gt_seen_q    <= 1'b0;
`ifdef AUTO_RESWEEP_EN
      rs_cnt_q     <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      pend_q       <= pend_d;
      park_cnt_q   <= park_cnt_d;
      pw_h_q       <= pw_h_d;
      pw_v_q       <= pw_v_d;
      act_h_q      <= act_h_d;
      act_v_q      <= act_v_d;
      pwm_en_q     <= pwm_en_d;
      pwm_h_q      <= pwm_h_d;
      pwm_v_q      <= pwm_v_d;
      en_h_q       <= en_h_d;
      en_v_q       <= en_v_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      gt_seen_q    <= gt_seen_d;
`ifdef AUTO_RESWEEP_EN
      rs_cnt_q     <= rs_cnt_d;
`endif
    end
  end

  assign pulseWidth_H = pw_h_q;
  assign pulseWidth_V = pw_v_q;
  assign EN_H         = en_h_q;
  assign EN_V         = en_v_q;
  assign SAMPLE       = point_done;
  assign PWM_H        = pwm_h_q;
  assign PWM_V        = pwm_v_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;

endmodule

// File: tb/tb_servo_sweep_ctrl.sv
// Directed bench for servo_sweep_ctrl with small frame parameters (PERIOD 100, widths 10..50).
module tb_servo_sweep_ctrl;

  logic        CLK = 1'b0;
  logic        RST, START, GT;
  logic [31:0] pulseWidth_max;
  logic [31:0] pulseWidth_H, pulseWidth_V;
  logic        EN_H, EN_V, SAMPLE, PWM_H, PWM_V, BUSY, DONE;

  servo_sweep_ctrl #(
    .PERIOD_CYC   (32'd100),
    .PW_MIN       (32'd10),
    .PW_MAX       (32'd50),
    .PW_STEP      (32'd10),
    .SETTLE_FRAMES(32'd1)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .START         (START),
    .GT            (GT),
    .pulseWidth_max(pulseWidth_max),
    .pulseWidth_H  (pulseWidth_H),
    .pulseWidth_V  (pulseWidth_V),
    .EN_H          (EN_H),
    .EN_V          (EN_V),
    .SAMPLE        (SAMPLE),
    .PWM_H         (PWM_H),
    .PWM_V         (PWM_V),
    .BUSY          (BUSY),
    .DONE          (DONE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc         = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // monitor: SAMPLE events and PWM high-run lengths
  int unsigned samp_cnt   = 0;
  int unsigned pwm_hi_cnt = 0;
  int unsigned samp_cyc_q[$];
  logic [31:0] samp_pw_q[$];
  logic [31:0] samp_other_q[$];
  logic [1:0]  samp_en_q[$];
  logic [31:0] run_h = 32'd0;
  logic [31:0] run_v = 32'd0;
  logic [31:0] runs_h_q[$];
  logic [31:0] runs_v_q[$];

  always @(negedge CLK) begin
    if (SAMPLE === 1'b1) begin
      samp_cnt <= samp_cnt + 1;
      samp_cyc_q.push_back(cyc);
      samp_pw_q.push_back(EN_H ? pulseWidth_H : pulseWidth_V);
      samp_other_q.push_back(EN_H ? pulseWidth_V : pulseWidth_H);
      samp_en_q.push_back({EN_H, EN_V});
    end
    if (PWM_H === 1'b1) run_h <= run_h + 32'd1;
    else if (run_h != 32'd0) begin
      runs_h_q.push_back(run_h);
      run_h <= 32'd0;
    end
    if (PWM_V === 1'b1) run_v <= run_v + 32'd1;
    else if (run_v != 32'd0) begin
      runs_v_q.push_back(run_v);
      run_v <= 32'd0;
    end
    if (PWM_H === 1'b1 || PWM_V === 1'b1) pwm_hi_cnt <= pwm_hi_cnt + 1;
  end

  // scoreboard
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns on the cycle after a SAMPLE strobe, bounded by a cycle budget.
  task automatic wait_sample(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (SAMPLE !== 1'b1 && n < 250);
    vectors++;
    assert (SAMPLE === 1'b1) else begin
      miscompares++;
      $error("FAIL %s sample_timeout observed=%0b expected=1", tag, SAMPLE);
    end
    @(negedge CLK);
  endtask

  int unsigned s0, hi0;

  initial begin
    RST = 1'b1; START = 1'b0; GT = 1'b0; pulseWidth_max = 32'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_pw_h", pulseWidth_H, 32'd30);
    chk("rst_pw_v", pulseWidth_V, 32'd30);
    chk("rst_en_h", {31'd0, EN_H}, 32'd0);
    chk("rst_en_v", {31'd0, EN_V}, 32'd0);
    chk("rst_sample", {31'd0, SAMPLE}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_pwm_h", {31'd0, PWM_H}, 32'd0);
    chk("rst_pwm_v", {31'd0, PWM_V}, 32'd0);
    RST = 1'b0;
    repeat (250) @(negedge CLK);
    chk("idle_pwm_low", pwm_hi_cnt, 32'd0);
    chk("idle_no_sample", samp_cnt, 32'd0);

    // sweep 1: no GT anywhere, array holds 30
    pulseWidth_max = 32'd30;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("s1_busy", {31'd0, BUSY}, 32'd1);
    chk("s1_en_h", {31'd0, EN_H}, 32'd1);
    chk("s1_pw_h_min", pulseWidth_H, 32'd10);
    chk("s1_done", {31'd0, DONE}, 32'd0);
    repeat (5) wait_sample("s1_h");
    chk("park_h_en_h", {31'd0, EN_H}, 32'd0);
    chk("park_h_en_v", {31'd0, EN_V}, 32'd0);
    chk("park_h_busy", {31'd0, BUSY}, 32'd1);
    repeat (2) @(negedge CLK);
    chk("park_h_pw_h", pulseWidth_H, 32'd30);
    chk("sweep_v_pw_v", pulseWidth_V, 32'd10);
    chk("sweep_v_en_v", {31'd0, EN_V}, 32'd1);
    chk("sweep_v_en_h", {31'd0, EN_H}, 32'd0);
    repeat (5) wait_sample("s1_v");
    chk("park_v_en_v", {31'd0, EN_V}, 32'd0);
    repeat (2) @(negedge CLK);
    chk("fin_busy", {31'd0, BUSY}, 32'd1);
    chk("fin_pw_v_mid", pulseWidth_V, 32'd30);
    @(negedge CLK);
    chk("end1_busy", {31'd0, BUSY}, 32'd0);
    chk("end1_done", {31'd0, DONE}, 32'd1);
    chk("end1_pw_h", pulseWidth_H, 32'd30);
    chk("s1_samp_cnt", samp_cnt, 32'd10);

    exp_q = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("s1_samp_pw[%0d]", i), samp_pw_q[i], exp_q[i]);
      chk($sformatf("s1_samp_other[%0d]", i), samp_other_q[i], 32'd30);
      chk($sformatf("s1_samp_en[%0d]", i), {30'd0, samp_en_q[i]}, (i < 5) ? 32'd2 : 32'd1);
    end
    for (int i = 1; i < 10; i++) begin
      chk($sformatf("s1_samp_gap[%0d]", i), samp_cyc_q[i] - samp_cyc_q[i-1],
          (i == 5) ? 32'd200 : 32'd100);
    end

    exp_q = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd50, 32'd30};
    chk("s1_runs_h_n", {31'd0, runs_h_q.size() >= 7}, 32'd1);
    for (int i = 0; i < 7; i++) chk($sformatf("s1_run_h[%0d]", i), runs_h_q[i], exp_q[i]);
    exp_q = '{32'd30, 32'd30, 32'd30, 32'd30, 32'd30, 32'd30,
              32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
    chk("s1_runs_v_n", {31'd0, runs_v_q.size() >= 11}, 32'd1);
    for (int i = 0; i < 11; i++) chk($sformatf("s1_run_v[%0d]", i), runs_v_q[i], exp_q[i]);

    repeat (150) @(negedge CLK);
    chk("idle_done_held", {31'd0, DONE}, 32'd1);
    chk("idle_busy_low", {31'd0, BUSY}, 32'd0);

    // sweep 2: GT only at V=40, array then reports 40; a START during BUSY is ignored
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("s2_done_clear", {31'd0, DONE}, 32'd0);
    chk("s2_busy", {31'd0, BUSY}, 32'd1);
    repeat (50) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (5) wait_sample("s2_h");
    repeat (3) wait_sample("s2_v");
    GT = 1'b1;
    wait_sample("s2_v40");
    GT = 1'b0;
    pulseWidth_max = 32'd40;
    wait_sample("s2_v50");
    repeat (3) @(negedge CLK);
    chk("s2_pw_v_win", pulseWidth_V, 32'd40);
    chk("s2_pw_h", pulseWidth_H, 32'd30);
    chk("s2_done", {31'd0, DONE}, 32'd1);
    chk("s2_busy_low", {31'd0, BUSY}, 32'd0);
    chk("s2_samp_cnt", samp_cnt, 32'd20);
    repeat (300) @(negedge CLK);
    chk("s2_no_resweep", samp_cnt, 32'd20);

    // sweep 3: reset while the third horizontal point is held
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) wait_sample("s3_h");
    chk("s3_third_point", pulseWidth_H, 32'd30);
    chk("s3_en_h", {31'd0, EN_H}, 32'd1);
    repeat (20) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("s3_rst_pw_h", pulseWidth_H, 32'd30);
    chk("s3_rst_en_h", {31'd0, EN_H}, 32'd0);
    chk("s3_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("s3_rst_done", {31'd0, DONE}, 32'd0);
    chk("s3_rst_pwm_h", {31'd0, PWM_H}, 32'd0);
    s0  = samp_cnt;
    hi0 = pwm_hi_cnt;
    repeat (300) @(negedge CLK);
    chk("s3_no_sample", samp_cnt, s0);
    chk("s3_pwm_low", pwm_hi_cnt, hi0);
    chk("s3_idle_en_h", {31'd0, EN_H}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
